// File: rtl/blockmix_ctrl.sv
// blockmix_ctrl: sequences 2R Salsa20/8 jobs over block B for scrypt BlockMix, writes shuffled Y.
// Latency: done in cycle 2 + 2R*(S+1) after start is sampled, S = core latency (not hard-wired).
// Backpressure: start honoured only in IDLE; optional watchdog (macro BLOCKMIX_TIMEOUT_EN) aborts a stuck WAIT.
module blockmix_ctrl #(
  parameter int R       = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [1024*R-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [1024*R-1:0] b_out,
  output logic              err,
  output logic [511:0]      salsa_data,
  output logic              salsa_enable,
  input  logic [511:0]      salsa_out,
  input  logic              salsa_done
);

  localparam int NB = 2 * R;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [511:0]  b_reg [NB];
  logic [511:0]  y_reg [NB];
  logic [511:0]  x_reg;
  logic [IW-1:0] idx;
  logic [IW-1:0] slot;
  logic          timeout_hit;

`ifdef BLOCKMIX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;

  // Watchdog: cleared while issuing (i.e. on entry to WAIT), counts every WAIT cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 wd_cnt <= '0;
    else if (state == S_ISSUE)  wd_cnt <= '0;
    else if (state == S_WAIT)   wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_WAIT) && !salsa_done && (wd_cnt == TW'(TIMEOUT));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // Even-indexed results fill the lower half of Y, odd-indexed the upper half.
  always_comb begin
    slot = idx[0] ? (IW'(R) + (idx >> 1)) : (idx >> 1);
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a late salsa_done outside WAIT is simply never looked at.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (salsa_done)       state_nxt = (idx == LAST) ? S_FINISH : S_ISSUE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the core operand is a pure function of registers so it stays stable.
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_FINISH);
    salsa_enable = (state == S_ISSUE);
    err          = timeout_hit;
    salsa_data   = x_reg ^ b_reg[idx];
  end

  // Datapath: capture B, seed X with the last sub-block, chain results and scatter them into Y.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_reg <= '0;
      idx   <= '0;
      for (int j = 0; j < NB; j++) begin
        b_reg[j] <= '0;
        y_reg[j] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int j = 0; j < NB; j++) b_reg[j] <= b_in[512*(NB-1-j) +: 512];
          end
        end
        S_LOAD: begin
          x_reg <= b_reg[NB-1];
          idx   <= '0;
        end
        S_WAIT: begin
          if (salsa_done) begin
            x_reg       <= salsa_out;
            y_reg[slot] <= salsa_out;
            if (idx != LAST) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pack Y with the same sub-block ordering as b_in.
  always_comb begin
    b_out = '0;
    for (int j = 0; j < NB; j++) b_out[512*(NB-1-j) +: 512] = y_reg[j];
  end

endmodule

// File: tb/tb_blockmix_ctrl.sv
// tb_blockmix_ctrl: random BlockMix jobs against a stub core with random latency.
// Reference builds Y from the even/odd result lists of the chained hash.
// Also covers start glitches, mid-job reset and a stalled core.
module tb_blockmix_ctrl;
  localparam int R       = 2;
  localparam int NB      = 2 * R;
  localparam int W       = 1024 * R;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  b_out;
  logic          err;
  logic [511:0]  salsa_data;
  logic          salsa_enable;
  logic [511:0]  salsa_out;
  logic          salsa_done;

  int n_vec = 0;
  int n_bad = 0;

  blockmix_ctrl #(.R(R), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .b_in(b_in),
    .busy(busy), .done(done), .b_out(b_out), .err(err),
    .salsa_data(salsa_data), .salsa_enable(salsa_enable),
    .salsa_out(salsa_out), .salsa_done(salsa_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for Salsa20/8: bijective and order-sensitive, so misplaced slots are visible.
  function automatic logic [511:0] hash(input logic [511:0] x);
    return {x[510:0], x[511]} ^ {16{32'h9e3779b9}};
  endfunction

  function automatic logic [W-1:0] rnd_blk();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[32*k +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- stub core ----------------
  int           lat_q[$];
  logic [511:0] ops[$];
  bit           stall = 1'b0;
  int           unstable = 0;
  logic [511:0] stub_op;
  int           stub_s;
  bit           stub_alive;

  initial begin
    salsa_done = 1'b0;
    salsa_out  = '0;
    forever begin
      @(negedge clk);
      if (n_rst && salsa_enable && !stall) begin
        stub_op = salsa_data;
        ops.push_back(stub_op);
        stub_s = (lat_q.size() > 0) ? lat_q.pop_front() : 34;
        stub_alive = 1'b1;
        for (int k = 1; k < stub_s; k++) begin
          @(negedge clk);
          if (!n_rst) begin
            stub_alive = 1'b0;
            break;
          end
          if (salsa_data !== stub_op) unstable++;
        end
        if (stub_alive) begin
          @(posedge clk);
          #1;
          if (n_rst) begin
            salsa_out  = hash(stub_op);
            salsa_done = 1'b1;
            @(negedge clk);
            if (salsa_data !== stub_op) unstable++;
            @(posedge clk);
            #1;
            salsa_done = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, 512'(busy), '0);
    chk({tag, "_done"}, 512'(done), '0);
    chk({tag, "_err"}, 512'(err), '0);
    chk({tag, "_salsa_enable"}, 512'(salsa_enable), '0);
    chk({tag, "_salsa_data"}, salsa_data, '0);
    for (int k = 0; k < NB; k++) chk({tag, "_b_out"}, b_out[512*(NB-1-k) +: 512], '0);
  endtask

  // One full BlockMix with random per-job core latency, optionally with stray start pulses.
  task automatic run_job(input logic [W-1:0] b, input bit glitch);
    logic [511:0] bb[NB];
    logic [511:0] opexp[NB];
    logic [511:0] yexp[NB];
    logic [511:0] ev[$];
    logic [511:0] od[$];
    logic [511:0] x;
    int exp_done, cyc, ndone, done_at, busy_bad, lat;

    for (int j = 0; j < NB; j++) bb[j] = b[512*(NB-1-j) +: 512];
    x = bb[NB-1];
    for (int i = 0; i < NB; i++) begin
      opexp[i] = x ^ bb[i];
      x = hash(opexp[i]);
      if (i % 2 == 0) ev.push_back(x);
      else            od.push_back(x);
    end
    for (int k = 0; k < R; k++) begin
      yexp[k]     = ev[k];
      yexp[R + k] = od[k];
    end

    exp_done = 2;
    lat_q.delete();
    for (int i = 0; i < NB; i++) begin
      lat = $urandom_range(1, 40);
      lat_q.push_back(lat);
      exp_done += lat + 1;
    end
    ops.delete();
    unstable = 0;
    ndone = 0; done_at = -1; busy_bad = 0;

    @(negedge clk);
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= exp_done + 1 && cyc < 3000) begin
      if (done) begin
        ndone++;
        done_at = cyc;
      end
      if (busy !== (cyc <= exp_done)) busy_bad++;
      start = glitch && (cyc == 5 || cyc == 40 || cyc == exp_done);
      b_in  = glitch ? rnd_blk() : b;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;

    chk("done_count", 512'(ndone), 512'(1));
    chk("done_cycle", 512'(done_at), 512'(exp_done));
    chk("busy_profile_errors", 512'(busy_bad), '0);
    chk("job_count", 512'(ops.size()), 512'(NB));
    for (int i = 0; i < NB; i++)
      chk("operand", (i < ops.size()) ? ops[i] : 'x, opexp[i]);
    chk("operand_unstable", 512'(unstable), '0);
    for (int k = 0; k < NB; k++) chk("b_out_slot", b_out[512*(NB-1-k) +: 512], yexp[k]);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [W-1:0] blk;
    int cyc, err_at, ndone;

    n_rst = 1'b0;
    start = 1'b0;
    b_in  = '0;
    #2;
    chk_idle_zero("reset");
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Zero block, structured constants, then random blocks.
    run_job('0, 1'b0);
    run_job({{16{32'haaaaaaaa}}, {16{32'h55555555}}, {16{32'hffffffff}}, {16{32'h01234567}}}, 1'b0);
    for (int t = 0; t < 4; t++) run_job(rnd_blk(), 1'b0);

    // Stray start pulses while busy (including during FINISH) must not disturb the job.
    blk = rnd_blk();
    run_job(blk, 1'b1);

    // Reset in the middle of a job: everything clears at once, then a fresh job completes.
    lat_q.delete();
    @(negedge clk);
    b_in  = rnd_blk();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    chk_idle_zero("midjob_reset");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    run_job(rnd_blk(), 1'b0);

    // Core that never answers.
    stall = 1'b1;
    @(negedge clk);
    b_in  = rnd_blk();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1; err_at = -1; ndone = 0;
`ifdef BLOCKMIX_TIMEOUT_EN
    while (cyc < 200) begin
      if (err) err_at = cyc;
      if (done) ndone++;
      if (cyc == 3 + TIMEOUT + 1) chk("busy_after_timeout", 512'(busy), '0);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("timeout_err_cycle", 512'(err_at), 512'(3 + TIMEOUT));
    chk("timeout_no_done", 512'(ndone), '0);
`else
    while (cyc < 200) begin
      if (err) err_at = cyc;
      if (done) ndone++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("stall_busy_held", 512'(busy), 512'(1));
    chk("stall_err_never", 512'(err_at), 512'(-1));
    chk("stall_no_done", 512'(ndone), '0);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
`endif
    stall = 1'b0;
    repeat (2) @(negedge clk);
    run_job(rnd_blk(), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/blockmix_ctrl.md
# blockmix_ctrl

Sequencer for the scrypt BlockMix step. It owns one `salsa20_8` core and issues 2R sequential hash jobs over a 1024·R-bit input block B. Each job computes X = Salsa20/8(X xor B[i]), starting from X = B[2R-1]. The results are written into the shuffled output order Y (even-indexed results first, then odd-indexed). The block sits between the scrypt ROMix controller and the salsa core.

## Interface
Parameters:
- R, 1, scrypt block-size factor; 2R 512-bit sub-blocks per job; R ≥ 1.
- TIMEOUT, 64, watchdog limit in cycles; used only when `BLOCKMIX_TIMEOUT_EN` is defined.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1, system clock, rising edge.
- n_rst, input, 1, asynchronous active-low reset.
- start, input, 1, begin a BlockMix; sampled only in IDLE.
- b_in, input, 1024·R, input block; sub-block j = b_in[512·(2R-1-j) +: 512].
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse; b_out valid.
- b_out, output, 1024·R, result Y, same sub-block indexing as b_in.
- err, output, 1, one-cycle pulse on watchdog abort; tied 0 without the macro.
- salsa_data, output, 512, operand to the core.
- salsa_enable, output, 1, one-cycle job request to the core.
- salsa_out, input, 512, core result.
- salsa_done, input, 1, one-cycle core completion pulse.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, FINISH.
- IDLE, start=1:
  - b_in is captured into the internal register B.
  - Go to LOAD. start in any other state is ignored.
- LOAD (1 cycle): X ← B[2R-1], i ← 0; go to ISSUE.
- ISSUE (1 cycle): salsa_enable=1; go to WAIT.
- salsa_data = X xor B[i]. It is driven from registers and held stable from ISSUE through the cycle salsa_done is seen.
- WAIT: remain until salsa_done=1. In that same cycle:
  - X ← salsa_out.
  - Y slot ← salsa_out. The slot is i/2 for even i, and R+(i-1)/2 for odd i.
  - If i=2R-1, go to FINISH. Otherwise i ← i+1 and go to ISSUE.
- FINISH (1 cycle): done=1; go to IDLE.
- b_out is the Y register. It is updated only by slot writes and holds its value after done until the next job writes slots.
- salsa_done in IDLE, LOAD, ISSUE or FINISH is ignored.
- Arithmetic: i is a ceil(log2(2R))-bit counter with no wrap; the last index terminates the job. The xor is 512-bit bitwise.
- Reset values: all states go to IDLE. busy, done, err and salsa_enable are 0. b_out, salsa_data, X, B and i are 0.
- Reset mid-job: the job is abandoned and no done is issued. The core is reset by the same n_rst.

## Timing
- Call the cycle in which start is sampled cycle 0. LOAD is cycle 1 and the first ISSUE is cycle 2.
- The core's salsa_done arrives S cycles after salsa_enable. S=34 for the current core, but the controller must not hard-wire S.
- The next ISSUE follows salsa_done by 1 cycle. This coincides with the core being back in IDLE.
- done is high in cycle 2 + 2R·(S+1); with S=34 that is 2 + 70R (72 for R=1).
- busy rises in cycle 1 and falls the cycle after done.
- A new start is accepted in the cycle after FINISH, so there is no back-to-back overlap.

## Configuration
- `BLOCKMIX_TIMEOUT_EN` defined:
  - A counter runs in WAIT and is cleared on entry to WAIT.
  - If TIMEOUT cycles pass without salsa_done, err pulses 1 cycle and the FSM returns to IDLE. No done is issued and b_out keeps its partial contents.
- Not defined: there is no counter, err is constant 0, and WAIT waits indefinitely.

## Test plan
- Real core, R=1, b_in=0 -> done in cycle 72 exactly once; b_out=0 (Salsa20/8 of zero is zero); busy high in cycles 1–72.
- Identity stub core (salsa_out=salsa_data, S=34), R=1, B0=0xAAAA…AA, B1=0x5555…55 -> job 0 operand 0xFFFF…FF, job 1 operand 0xAAAA…AA; b_out={0xFFFF…FF (slot 0), 0xAAAA…AA (slot 1)}.
- Same stub, R=2, B0..B3 = distinct constants -> slot order {X0, X2, X1, X3}; done in cycle 142.
- start pulses in cycles 5, 40 and 72 of a running job -> ignored; exactly one done; result unchanged vs. the single-start run.
- n_rst low at cycle 20 of a job -> all outputs 0 immediately; a subsequent start completes normally with correct b_out.
- With the macro, stub that never asserts salsa_done, TIMEOUT=64 -> err in cycle 2+1+64, busy 0 the next cycle, done never high; without the macro, busy stays high.
